// File: rtl/psum_serial_acc_pkg.sv
// Shared hardware constants for the bit-serial partial-sum accumulator.
// Holds the default widths and the ACC/FULL state encoding.
package psum_serial_acc_pkg;

  localparam int unsigned HW_PSU_DW = 12;
  localparam int unsigned HW_IDX_DW = 4;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

endpackage

// File: rtl/sat_add.sv
// Two's-complement adder that clamps to the signed W-bit range on overflow.
// sat flags any cycle where clamping happened.
module sat_add #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);

  logic [W-1:0] raw;

  assign raw = a + b;

  always_comb begin
    // Overflow only when both operands share a sign that the raw sum loses.
    sat = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    sum = raw;
    if (sat) begin
      sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/psum_serial_acc.sv
// Accumulates signed digit products of one weight group into a saturating sum
// and hands the result over through a one-deep valid/ready output register.
module psum_serial_acc
  import psum_serial_acc_pkg::*;
#(
  parameter int unsigned PSU_DW  = HW_PSU_DW,
  parameter int unsigned ACC_DW  = HW_PSU_DW + 8,
  parameter int unsigned MAX_DIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PSU_DW-1:0] psu_in,
  input  logic              neg_in,
  input  logic              last_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_DW-1:0] acc_out,
  output logic              ovf_out
);

  localparam int unsigned CNT_DW = (MAX_DIG > 1) ? $clog2(MAX_DIG) : 1;

  logic [0:0]        state_q;
  logic [ACC_DW-1:0] acc_q;
  logic [CNT_DW-1:0] cnt_q;
  logic              ovf_q;

  logic [ACC_DW-1:0] ext;
  logic [ACC_DW-1:0] addend;
  logic [ACC_DW-1:0] sum;
  logic              sat;
  logic              accept;
  logic              at_max;
  logic              close;

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;

  assign ext    = {{(ACC_DW - PSU_DW){1'b0}}, psu_in};
  assign addend = neg_in ? (~ext + ACC_DW'(1)) : ext;

  assign accept = in_valid && in_ready && !clr;
  assign at_max = (cnt_q == CNT_DW'(MAX_DIG - 1));
  assign close  = accept && (last_in || at_max);

  sat_add #(
    .W (ACC_DW)
  ) u_sat_add (
    .a   (acc_q),
    .b   (addend),
    .sum (sum),
    .sat (sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      acc_out <= '0;
      ovf_out <= 1'b0;
    end else begin
      if (clr || close) begin
        acc_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (accept) begin
        acc_q <= sum;
        cnt_q <= cnt_q + CNT_DW'(1);
        ovf_q <= ovf_q | sat;
      end

      // A close while the old result is being taken reloads without a bubble.
      if (close) begin
        state_q <= ST_FULL;
        acc_out <= sum;
        ovf_out <= ovf_q | sat | (at_max && !last_in);
      end else if (out_valid && out_ready) begin
        state_q <= ST_ACC;
      end
    end
  end

endmodule

// File: tb/tb_psum_serial_acc.sv
// Drives two accumulators (20-bit and 14-bit) with the same digit stream and
// checks both against a cycle-level reference model through result queues.
module tb_psum_serial_acc;

  typedef struct {
    longint acc;
    bit     ovf;
  } res_t;

  localparam int MAX_DIG = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic [11:0] psu_in;
  logic        neg_in;
  logic        last_in;
  logic        out_ready;

  logic        in_ready0, out_valid0, ovf0;
  logic [19:0] acc0;
  logic        in_ready1, out_valid1, ovf1;
  logic [13:0] acc1;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned aw[2] = '{20, 14};
  longint      macc[2];
  int          mcnt[2];
  bit          movf[2];
  bit          mfull[2];
  res_t        sb[2][$];
  longint      log_acc[2][$];
  bit          log_ovf[2][$];

  always #5 clk = ~clk;

  psum_serial_acc #(
    .PSU_DW  (12),
    .ACC_DW  (20),
    .MAX_DIG (MAX_DIG)
  ) dut0 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .psu_in    (psu_in),
    .neg_in    (neg_in),
    .last_in   (last_in),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .acc_out   (acc0),
    .ovf_out   (ovf0)
  );

  psum_serial_acc #(
    .PSU_DW  (12),
    .ACC_DW  (14),
    .MAX_DIG (MAX_DIG)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .psu_in    (psu_in),
    .neg_in    (neg_in),
    .last_in   (last_in),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .acc_out   (acc1),
    .ovf_out   (ovf1)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle on stable inputs.
  always @(negedge clk) begin : model
    bit     g_rdy[2];
    bit     g_vld[2];
    bit     g_ovf[2];
    longint g_acc[2];
    longint s, mx, mn;
    bit     sat, acc_ok, cls;
    res_t   r;

    g_rdy[0] = in_ready0;  g_vld[0] = out_valid0;
    g_ovf[0] = ovf0;       g_acc[0] = longint'($signed(acc0));
    g_rdy[1] = in_ready1;  g_vld[1] = out_valid1;
    g_ovf[1] = ovf1;       g_acc[1] = longint'($signed(acc1));

    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        macc[k] = 0; mcnt[k] = 0; movf[k] = 0; mfull[k] = 0;
        sb[k].delete();
      end else begin
        check_val($sformatf("in_ready%0d", k), longint'(g_rdy[k]),
                  longint'(!mfull[k] || out_ready));
        check_val($sformatf("out_valid%0d", k), longint'(g_vld[k]), longint'(mfull[k]));
        if (mfull[k] && sb[k].size() > 0) begin
          check_val($sformatf("acc_out%0d", k), g_acc[k], sb[k][0].acc);
          check_val($sformatf("ovf_out%0d", k), longint'(g_ovf[k]), longint'(sb[k][0].ovf));
          if (out_ready) begin
            log_acc[k].push_back(g_acc[k]);
            log_ovf[k].push_back(g_ovf[k]);
            void'(sb[k].pop_front());
          end
        end

        mx = (longint'(1) << (aw[k] - 1)) - 1;
        mn = -(longint'(1) << (aw[k] - 1));
        acc_ok = !clr && in_valid && (!mfull[k] || out_ready);
        s = macc[k] + (neg_in ? -longint'(psu_in) : longint'(psu_in));
        sat = 0;
        if (s > mx) begin s = mx; sat = 1; end
        if (s < mn) begin s = mn; sat = 1; end
        cls = acc_ok && (last_in || mcnt[k] == MAX_DIG - 1);

        if (clr) begin
          macc[k] = 0; mcnt[k] = 0; movf[k] = 0;
        end
        if (cls) begin
          r.acc = s;
          r.ovf = movf[k] | sat | !last_in;
          sb[k].push_back(r);
          macc[k] = 0; mcnt[k] = 0; movf[k] = 0;
          mfull[k] = 1;
        end else begin
          if (acc_ok) begin
            macc[k] = s;
            mcnt[k]++;
            movf[k] = movf[k] | sat;
          end
          if (mfull[k] && out_ready) mfull[k] = 0;
        end
      end
    end
  end

  task automatic drive(input logic [11:0] p, input bit n, input bit l, input bit ordy);
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b1; psu_in = p; neg_in = n; last_in = l; out_ready = ordy;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0; last_in = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; psu_in = '0;
    neg_in = 1'b0; last_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_in_ready", longint'(in_ready0), 1);
    check_val("reset_acc_out", longint'(acc0), 0);
    rst = 1'b0;

    // +96, -24, +6 -> 78
    drive(96, 0, 0, 1); drive(24, 1, 0, 1); drive(6, 0, 1, 1); idle();

    // Held result with the next group stalled behind it.
    drive(10, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(3, 0, 0, 0);
      if (i == 2) begin
        #1;
        check_val("stall_in_ready", longint'(in_ready0), 0);
        check_val("stall_acc_out", longint'(acc0), 10);
      end
    end
    drive(3, 0, 0, 1); drive(4, 0, 1, 1); idle();

    // Back-to-back single-digit groups.
    for (int i = 1; i <= 4; i++) drive(12'(i), 0, 1, 1);
    idle();

    // Positive saturation on the narrow instance.
    for (int i = 0; i < 4; i++) drive(4095, 0, i == 3, 1);
    idle();

    // Forced close with no last.
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 1);
    idle();

    // clr drops the partial sum and the digit presented with it.
    drive(50, 0, 0, 1);
    @(posedge clk);
    #1;
    clr = 1'b1; in_valid = 1'b1; psu_in = 7; neg_in = 1'b0; last_in = 1'b1;
    drive(2, 0, 1, 1); idle();

    // Negative saturation on the narrow instance.
    for (int i = 0; i < 3; i++) drive(4095, 1, i == 2, 1);
    idle();

    // Asynchronous reset in mid-group.
    drive(9, 0, 0, 1); drive(9, 0, 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_acc_out", longint'(acc0), 0);
    check_val("async_rst_out_valid", longint'(out_valid0), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(5, 0, 1, 1);
    repeat (3) idle();

    check_val("sb0_empty", longint'(sb[0].size()), 0);
    check_val("sb1_empty", longint'(sb[1].size()), 0);
    check_val("results0", longint'(log_acc[0].size()), 12);
    check_val("results1", longint'(log_acc[1].size()), 12);
    if (log_acc[0].size() == 12 && log_acc[1].size() == 12) begin
      check_val("g1_acc", log_acc[0][0], 78);
      check_val("g1_ovf", longint'(log_ovf[0][0]), 0);
      check_val("stall_g1", log_acc[0][1], 10);
      check_val("stall_g2", log_acc[0][2], 7);
      for (int i = 0; i < 4; i++) check_val($sformatf("b2b_%0d", i), log_acc[0][3 + i], i + 1);
      check_val("sat_pos_acc", log_acc[1][7], 8191);
      check_val("sat_pos_ovf", longint'(log_ovf[1][7]), 1);
      check_val("wide_acc", log_acc[0][7], 16380);
      check_val("forced_acc", log_acc[0][8], 4);
      check_val("forced_ovf", longint'(log_ovf[0][8]), 1);
      check_val("clr_acc", log_acc[0][9], 2);
      check_val("sat_neg_acc", log_acc[1][10], -8192);
      check_val("sat_neg_ovf", longint'(log_ovf[1][10]), 1);
      check_val("post_rst_acc", log_acc[0][11], 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
